conv2_add6_feed: RTL

CONV2_ADD6_FEED -- requirements
Module: conv2_add6_feed

---
 rtl/conv2_add6_feed_pkg.sv | 19 +
 rtl/conv2_add6_feed_if.sv | 15 +
 rtl/conv2_add6_feed_lane_bank.sv | 30 +++
 rtl/conv2_add6_feed.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/conv2_add6_feed_pkg.sv
// Shared LeNet conv2 feed definitions: channel count, issue timing, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv2_add6_feed_pkg;

  localparam int N_CH       = 6;   // channel partial sums per output pixel
  localparam int ISSUE_HOLD = 2;   // cycles ena stays high per pixel
  localparam int OUT_LAT    = 3;   // out_valid lands in the 3rd cycle, counting the first ena cycle as 1
  localparam int CH_W       = $clog2(N_CH);
  localparam int HOLD_W     = $clog2(ISSUE_HOLD);
  localparam int PIX_W      = 7;   // 10x10 map index

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_DRAIN  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/conv2_add6_feed_if.sv
// Channel partial-sum stream into the conv2 adder feed (valid/ready).
// Latency: n/a (wires only).
// Backpressure: sink holds in_ready low to stall the source.
//   master: drives in_valid/in_data, observes in_ready
//   slave : observes in_valid/in_data, drives in_ready
interface conv2_add6_feed_if #(
  parameter int DATA_SIZE = 16
);
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATA_SIZE-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/conv2_add6_feed_lane_bank.sv
// Six-lane register bank: single-lane indexed write or parallel load of all lanes.
// Latency: 1 cycle from write/copy to lanes.
// Backpressure: none; parallel copy takes priority over the indexed write.
//   ports: clk, rst (sync active-low), wr_en/wr_idx/wr_dat, cp_en/cp_dat, lanes
module conv2_lane_bank
  import conv2_add6_feed_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [CH_W-1:0]                 wr_idx,
  input  logic [DATA_SIZE-1:0]            wr_dat,
  input  logic                            cp_en,
  input  logic [N_CH-1:0][DATA_SIZE-1:0]  cp_dat,
  output logic [N_CH-1:0][DATA_SIZE-1:0]  lanes
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      lanes <= '0;
    end else if (cp_en) begin
      lanes <= cp_dat;
    end else if (wr_en) begin
      lanes[wr_idx] <= wr_dat;
    end
  end

endmodule

// File: rtl/conv2_add6_feed.sv
// Gathers six channel partial sums per pixel and feeds them, with the frame bias, to the 6-input adder.
// Latency: 2 cycles from 6th channel transfer to first ena; out_valid the cycle after the 2nd ena cycle.
// Backpressure: in_ready drops while the gather bank is full and the issue bank is still issuing.
//   ports: clk, rst (sync active-low), start/bias_in (frame control), s_in (channel stream),
//          din1..din6/bias/ena (adder feed), out_valid/pix_idx/frame_done (result marking)
module conv2_add6_feed
  import conv2_add6_feed_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int N_PIX     = 100
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [DATA_SIZE-1:0] bias_in,
  conv2_add6_feed_if.slave            s_in,
  output logic signed [DATA_SIZE-1:0] din1,
  output logic signed [DATA_SIZE-1:0] din2,
  output logic signed [DATA_SIZE-1:0] din3,
  output logic signed [DATA_SIZE-1:0] din4,
  output logic signed [DATA_SIZE-1:0] din5,
  output logic signed [DATA_SIZE-1:0] din6,
  output logic signed [DATA_SIZE-1:0] bias,
  output logic                        ena,
  output logic                        out_valid,
  output logic [PIX_W-1:0]            pix_idx,
  output logic                        frame_done
);

  feed_state_t state, state_nxt;

  logic [CH_W-1:0]   ch_cnt;
  logic [PIX_W-1:0]  pix_cnt;     // pixels fully gathered this frame
  logic [PIX_W-1:0]  out_cnt;     // pixels issued this frame; issue order equals gather order
  logic [HOLD_W-1:0] hold_cnt;
  logic              gather_full;

  logic xfer, last_ch, hold_last, issue_free, copy, last_out, start_acc;

  logic [N_CH-1:0][DATA_SIZE-1:0] g_lanes;
  logic [N_CH-1:0][DATA_SIZE-1:0] i_lanes;

  // The issue bank may be reloaded in its final ena cycle: the adder has
  // already seen the lanes for the required hold time by that edge.
  assign hold_last  = ena && (hold_cnt == HOLD_W'(ISSUE_HOLD - 1));
  assign issue_free = !ena || hold_last;
  assign copy       = gather_full && issue_free;

  assign s_in.in_ready = (state == ST_GATHER) && (!gather_full || issue_free);
  assign xfer          = s_in.in_valid && s_in.in_ready;
  assign last_ch       = (ch_cnt == CH_W'(N_CH - 1));
  assign last_out      = hold_last && (out_cnt == PIX_W'(N_PIX - 1));
  assign start_acc     = (state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start) state_nxt = ST_GATHER;
      ST_GATHER: if (xfer && last_ch && (pix_cnt == PIX_W'(N_PIX - 1))) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (last_out) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_cnt      <= '0;
      pix_cnt     <= '0;
      out_cnt     <= '0;
      hold_cnt    <= '0;
      gather_full <= 1'b0;
      bias        <= '0;
      ena         <= 1'b0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      pix_idx     <= '0;
    end else begin
      if (start_acc) begin
        bias        <= bias_in;
        ch_cnt      <= '0;
        pix_cnt     <= '0;
        out_cnt     <= '0;
        gather_full <= 1'b0;
      end

      if (xfer) begin
        ch_cnt <= last_ch ? '0 : ch_cnt + CH_W'(1);
        if (last_ch) begin
          pix_cnt <= pix_cnt + PIX_W'(1);
        end
      end

      // A full bank always has ch_cnt at 0, so a copy never coincides with
      // the write that fills the bank again.
      if (copy) begin
        gather_full <= 1'b0;
      end
      if (xfer && last_ch) begin
        gather_full <= 1'b1;
      end

      if (copy) begin
        ena      <= 1'b1;
        hold_cnt <= '0;
      end else if (hold_last) begin
        ena      <= 1'b0;
      end else if (ena) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end

      out_valid  <= hold_last;
      frame_done <= last_out;
      if (hold_last) begin
        pix_idx <= out_cnt;
        out_cnt <= out_cnt + PIX_W'(1);
      end
    end
  end

  conv2_lane_bank #(.DATA_SIZE(DATA_SIZE)) u_gather (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (xfer),
    .wr_idx (ch_cnt),
    .wr_dat (s_in.in_data),
    .cp_en  (1'b0),
    .cp_dat ('0),
    .lanes  (g_lanes)
  );

  conv2_lane_bank #(.DATA_SIZE(DATA_SIZE)) u_issue (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (1'b0),
    .wr_idx ('0),
    .wr_dat ('0),
    .cp_en  (copy),
    .cp_dat (g_lanes),
    .lanes  (i_lanes)
  );

  // The adder lanes come straight from the issue bank, which only changes on
  // a copy, so they hold steady whenever ena is low.
  assign din1 = i_lanes[0];
  assign din2 = i_lanes[1];
  assign din3 = i_lanes[2];
  assign din4 = i_lanes[3];
  assign din5 = i_lanes[4];
  assign din6 = i_lanes[5];

endmodule
